pc_sequencer: RTL and testbench

- Program-counter and fetch-sequencing stage. It drives the instruction-memory address and produces the inst_memory_exception input consumed by the central control unit.
- It takes back from the control unit jump, halt and the 2-bit branch code, together with the comparison operands and targets from the datapath. It selects the next PC, tracks run/halt state and counts retired instructions.
- It also records why the CPU stopped.

---
 rtl/ctrl_pkg.sv | 24 ++
 rtl/branch_resolve.sv | 28 ++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: encodings shared by the fetch sequencer and the central control unit.
//   - BR_*  : 2-bit branch codes that control drives onto the branch input.
//   - ST_*  : run/halt state encoding of the sequencer.
//   - HC_*  : bit positions inside the sticky halt_cause vector.
package ctrl_pkg;

    localparam int BR_W = 2;

    localparam logic [BR_W-1:0] BR_NONE = 2'b00;
    localparam logic [BR_W-1:0] BR_BEQ  = 2'b01;
    localparam logic [BR_W-1:0] BR_BGT  = 2'b10;
    localparam logic [BR_W-1:0] BR_BLT  = 2'b11;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    localparam int HC_ALU  = 0;
    localparam int HC_DMEM = 1;
    localparam int HC_IMEM = 2;

endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: purely combinational branch-condition evaluation.
// Ports:
//   branch  - branch code (BR_NONE/BR_BEQ/BR_BGT/BR_BLT)
//   op_a    - first compare operand, two's complement
//   op_b    - second compare operand, two's complement
//   taken   - high when the selected condition holds
module branch_resolve
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [BR_W-1:0]  branch,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             taken
);

    always_comb begin
        taken = 1'b0;
        case (branch)
            BR_BEQ:  taken = (op_a == op_b);
            BR_BGT:  taken = ($signed(op_a) > $signed(op_b));
            BR_BLT:  taken = ($signed(op_a) < $signed(op_b));
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencing.
// Selects the next PC (halt > stall > jump > taken branch > pc+2), tracks the
// START/RUN/HALTED state, counts retired instructions and records why the CPU
// stopped.
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   stall                    - hold current instruction; freezes pc and retired
//   jump, halt, branch       - sequencing commands from control
//   op_a, op_b               - signed compare operands for branches
//   branch_offset            - signed word offset (sign-extended)
//   jump_target              - absolute byte address for jumps
//   alu_exception            - captured into halt_cause only
//   data_memory_exception    - captured into halt_cause only
//   pc                       - registered fetch address
//   inst_memory_exception    - pc odd or outside instruction memory (in RUN)
//   running, halted          - state decode
//   halt_cause               - sticky {inst_mem, data_mem, alu}; 000 = clean HALT
//   retired                  - completed-instruction count (wraps)
//   dbg_state                - raw FSM state for observation
module pc_sequencer
    import ctrl_pkg::*;
#(
    parameter int                     PC_WIDTH             = 16,
    parameter logic [PC_WIDTH-1:0]    IMEM_BYTES           = 16'd512,
    parameter logic [PC_WIDTH-1:0]    RESET_PC             = 16'h0000,
    parameter int                     BRANCH_CONTROL_WIDTH = 2,
    parameter int                     COUNT_WIDTH          = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic                            jump,
    input  logic                            halt,
    input  logic [BRANCH_CONTROL_WIDTH-1:0] branch,
    input  logic [PC_WIDTH-1:0]             op_a,
    input  logic [PC_WIDTH-1:0]             op_b,
    input  logic [PC_WIDTH-1:0]             branch_offset,
    input  logic [PC_WIDTH-1:0]             jump_target,
    input  logic                            alu_exception,
    input  logic                            data_memory_exception,
    output logic [PC_WIDTH-1:0]             pc,
    output logic                            inst_memory_exception,
    output logic                            running,
    output logic                            halted,
    output logic [2:0]                      halt_cause,
    output logic [COUNT_WIDTH-1:0]          retired,
    output seq_state_t                      dbg_state
);

    seq_state_t          state;
    logic                taken;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] branch_pc;

    branch_resolve #(
        .WIDTH (PC_WIDTH)
    ) u_branch_resolve (
        .branch (branch[BR_W-1:0]),
        .op_a   (op_a),
        .op_b   (op_b),
        .taken  (taken)
    );

    // Word offset becomes a byte offset by a left shift; both sums wrap
    // naturally at 2^PC_WIDTH.
    assign seq_pc    = pc + PC_WIDTH'(2);
    assign branch_pc = seq_pc + {branch_offset[PC_WIDTH-2:0], 1'b0};

    // Outputs decode registered state only, so nothing from halt/jump/branch
    // reaches pc or the status outputs combinationally.
    assign running   = (state == ST_RUN);
    assign halted    = (state == ST_HALTED);
    assign dbg_state = state;

    assign inst_memory_exception = running & (pc[0] | (pc >= IMEM_BYTES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_START;
            pc         <= RESET_PC;
            halt_cause <= 3'b000;
            retired    <= '0;
        end else begin
            case (state)
                // One settle cycle for instruction memory; pc is untouched.
                ST_START: state <= ST_RUN;

                ST_RUN: begin
                    if (halt) begin
                        // The halting instruction is not counted as retired.
                        state               <= ST_HALTED;
                        halt_cause[HC_IMEM] <= inst_memory_exception;
                        halt_cause[HC_DMEM] <= data_memory_exception;
                        halt_cause[HC_ALU]  <= alu_exception;
                    end else if (!stall) begin
                        retired <= retired + COUNT_WIDTH'(1);
                        if (jump)
                            pc <= jump_target;
                        else if (taken)
                            pc <= branch_pc;
                        else
                            pc <= seq_pc;
                    end
                end

                // Terminal: everything frozen until rst.
                ST_HALTED: state <= ST_HALTED;

                default: state <= ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed tests for pc_sequencer with hand-computed
// expectations. Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point.
module tb_pc_sequencer;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        halt = 1'b0;
    logic [1:0]  branch = 2'b00;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] branch_offset = '0;
    logic [15:0] jump_target = '0;
    logic        alu_exception = 1'b0;
    logic        data_memory_exception = 1'b0;
    logic [15:0] pc;
    logic        inst_memory_exception;
    logic        running;
    logic        halted;
    logic [2:0]  halt_cause;
    logic [15:0] retired;
    seq_state_t  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall                 (stall),
        .jump                  (jump),
        .halt                  (halt),
        .branch                (branch),
        .op_a                  (op_a),
        .op_b                  (op_b),
        .branch_offset         (branch_offset),
        .jump_target           (jump_target),
        .alu_exception         (alu_exception),
        .data_memory_exception (data_memory_exception),
        .pc                    (pc),
        .inst_memory_exception (inst_memory_exception),
        .running               (running),
        .halted                (halted),
        .halt_cause            (halt_cause),
        .retired               (retired),
        .dbg_state             (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; jump = 0; halt = 0; branch = BR_NONE;
        op_a = '0; op_b = '0; branch_offset = '0; jump_target = '0;
        alu_exception = 0; data_memory_exception = 0;
    endtask

    // Reset, release, and pass the START cycle: leaves pc=0, retired=0, RUN.
    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic do_jump(input logic [15:0] target);
        jump = 1; jump_target = target;
        tick();
        jump = 0;
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc got=%h exp=0000", pc); end
        n_checks++; if ({running, halted} !== 2'b00) begin n_fail++; $display("FAIL rst_state got run=%b halt=%b exp=00", running, halted); end
        n_checks++; if (halt_cause !== 3'b000) begin n_fail++; $display("FAIL rst_cause got=%b exp=000", halt_cause); end
        n_checks++; if (retired !== 16'd0) begin n_fail++; $display("FAIL rst_retired got=%0d exp=0", retired); end
        n_checks++; if (inst_memory_exception !== 1'b0) begin n_fail++; $display("FAIL rst_ime got=%b exp=0", inst_memory_exception); end
        n_checks++; if (dbg_state !== ST_START) begin n_fail++; $display("FAIL rst_dbg_state got=%0d exp=%0d", dbg_state, ST_START); end
        rst = 0;
        // Still in START until the next edge.
        #2;
        n_checks++; if (running !== 1'b0 || pc !== 16'h0000) begin n_fail++; $display("FAIL start_cycle got run=%b pc=%h exp run=0 pc=0000", running, pc); end
        tick();
        n_checks++; if (running !== 1'b1 || pc !== 16'h0000) begin n_fail++; $display("FAIL start_to_run got run=%b pc=%h exp run=1 pc=0000", running, pc); end
        tick();
        n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL seq_pc1 got=%h exp=0002", pc); end
        tick();
        n_checks++; if (pc !== 16'h0004) begin n_fail++; $display("FAIL seq_pc2 got=%h exp=0004", pc); end
        tick();
        n_checks++; if (pc !== 16'h0006) begin n_fail++; $display("FAIL seq_pc3 got=%h exp=0006", pc); end
        n_checks++; if (retired !== 16'd3) begin n_fail++; $display("FAIL seq_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_blt();
        apply_reset();
        do_jump(16'h0010);
        n_checks++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL jump_0010 got=%h exp=0010", pc); end
        branch = BR_BLT; op_a = 16'hFFFF; op_b = 16'h0001; branch_offset = 16'hFFFE;
        tick();
        n_checks++; if (pc !== 16'h000E) begin n_fail++; $display("FAIL blt_taken got=%h exp=000E", pc); end
        branch = BR_NONE;
        do_jump(16'h0010);
        branch = BR_BLT; op_a = 16'h0002;
        tick();
        n_checks++; if (pc !== 16'h0012) begin n_fail++; $display("FAIL blt_not_taken got=%h exp=0012", pc); end
        branch = BR_NONE;
    endtask

    task automatic test_beq_bgt_jump();
        apply_reset();
        do_jump(16'h0020);
        branch = BR_BEQ; op_a = 16'h1234; op_b = 16'h1234; branch_offset = 16'h0004;
        tick();
        n_checks++; if (pc !== 16'h002A) begin n_fail++; $display("FAIL beq_taken got=%h exp=002A", pc); end
        branch = BR_BGT; op_a = 16'h0005; op_b = 16'hFFFF; branch_offset = 16'h0001;
        tick();
        n_checks++; if (pc !== 16'h002E) begin n_fail++; $display("FAIL bgt_signed_taken got=%h exp=002E", pc); end
        op_a = 16'hFFFF; op_b = 16'h0001;
        tick();
        n_checks++; if (pc !== 16'h0030) begin n_fail++; $display("FAIL bgt_signed_not_taken got=%h exp=0030", pc); end
        op_a = 16'h0005; op_b = 16'h0001; jump = 1; jump_target = 16'h0100;
        tick();
        n_checks++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL jump_over_branch got=%h exp=0100", pc); end
        n_checks++; if (retired !== 16'd5) begin n_fail++; $display("FAIL branch_retired got=%0d exp=5", retired); end
        idle_inputs();
    endtask

    task automatic test_stall_halt();
        apply_reset();
        do_jump(16'h0040);
        stall = 1;
        repeat (3) tick();
        n_checks++; if (pc !== 16'h0040) begin n_fail++; $display("FAIL stall_pc got=%h exp=0040", pc); end
        n_checks++; if (retired !== 16'd1) begin n_fail++; $display("FAIL stall_retired got=%0d exp=1", retired); end
        halt = 1;
        tick();
        n_checks++; if (halted !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL halt_over_stall got halted=%b running=%b exp 1/0", halted, running); end
        n_checks++; if (halt_cause !== 3'b000) begin n_fail++; $display("FAIL clean_halt_cause got=%b exp=000", halt_cause); end
        n_checks++; if (pc !== 16'h0040 || retired !== 16'd1) begin n_fail++; $display("FAIL halt_freeze got pc=%h ret=%0d exp 0040/1", pc, retired); end
        halt = 0; stall = 0;
        jump = 1; jump_target = 16'h0100; tick();
        jump = 0; tick();
        jump = 1; tick();
        jump = 0;
        n_checks++; if (pc !== 16'h0040 || retired !== 16'd1 || halted !== 1'b1) begin n_fail++; $display("FAIL halted_ignores got pc=%h ret=%0d halted=%b exp 0040/1/1", pc, retired, halted); end
        idle_inputs();
    endtask

    task automatic test_imem_exception();
        apply_reset();
        do_jump(16'h01FE);
        n_checks++; if (inst_memory_exception !== 1'b0) begin n_fail++; $display("FAIL ime_last_word got=%b exp=0", inst_memory_exception); end
        do_jump(16'h0200);
        n_checks++; if (inst_memory_exception !== 1'b1) begin n_fail++; $display("FAIL ime_out_of_range got=%b exp=1", inst_memory_exception); end
        halt = 1;
        tick();
        halt = 0;
        n_checks++; if (halt_cause !== 3'b100 || halted !== 1'b1) begin n_fail++; $display("FAIL ime_halt got cause=%b halted=%b exp 100/1", halt_cause, halted); end
        // Odd target, with an ALU exception raised in the same halt cycle.
        apply_reset();
        do_jump(16'h0033);
        n_checks++; if (inst_memory_exception !== 1'b1) begin n_fail++; $display("FAIL ime_odd got=%b exp=1", inst_memory_exception); end
        alu_exception = 1; halt = 1;
        tick();
        idle_inputs();
        n_checks++; if (halt_cause !== 3'b101) begin n_fail++; $display("FAIL odd_alu_cause got=%b exp=101", halt_cause); end
        // Data-memory cause alone.
        apply_reset();
        data_memory_exception = 1; halt = 1;
        tick();
        idle_inputs();
        n_checks++; if (halt_cause !== 3'b010) begin n_fail++; $display("FAIL dmem_cause got=%b exp=010", halt_cause); end
    endtask

    task automatic test_async_reset();
        // Leftover from previous test: halted with cause 010.
        rst = 1;
        #1;
        n_checks++; if (halt_cause !== 3'b000 || halted !== 1'b0) begin n_fail++; $display("FAIL rst_clears_cause got cause=%b halted=%b exp 000/0", halt_cause, halted); end
        rst = 0;
        apply_reset();
        do_jump(16'h0080);
        tick();
        stall = 1;
        tick();
        n_checks++; if (pc !== 16'h0082 || retired !== 16'd2) begin n_fail++; $display("FAIL pre_async got pc=%h ret=%0d exp 0082/2", pc, retired); end
        #2;
        rst = 1;
        #1;
        n_checks++; if (pc !== 16'h0000 || retired !== 16'd0 || running !== 1'b0) begin n_fail++; $display("FAIL async_rst got pc=%h ret=%0d run=%b exp 0000/0/0", pc, retired, running); end
        idle_inputs();
        rst = 0;
    endtask

    task automatic test_wrap();
        apply_reset();
        do_jump(16'hFFFE);
        n_checks++; if (inst_memory_exception !== 1'b1) begin n_fail++; $display("FAIL ime_fffe got=%b exp=1", inst_memory_exception); end
        tick();
        n_checks++; if (pc !== 16'h0000 || running !== 1'b1) begin n_fail++; $display("FAIL pc_wrap got pc=%h run=%b exp 0000/1", pc, running); end
        n_checks++; if (inst_memory_exception !== 1'b0) begin n_fail++; $display("FAIL ime_after_wrap got=%b exp=0", inst_memory_exception); end
        // Branch target arithmetic wraps too: 0000 + 2 + (-2<<1) = FFFE.
        branch = BR_BEQ; op_a = 16'h0007; op_b = 16'h0007; branch_offset = 16'hFFFE;
        tick();
        n_checks++; if (pc !== 16'hFFFE) begin n_fail++; $display("FAIL branch_wrap got=%h exp=FFFE", pc); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_blt();
        test_beq_bgt_jump();
        test_stall_halt();
        test_imem_exception();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
